branch_cmp_sched: RTL and testbench
===================================

BRANCH_CMP_SCHED -- requirements
Module: branch_cmp_sched

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester branch request valid.
REQ-005 req_ready  out  2  per-requester acceptance; one-hot or zero.
REQ-006 req_func3  in  2x3  branch func3 per requester: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-007 req_rs1, req_rs2  in  2x32 each  compare operands per requester.
REQ-008 req_pc, req_off  in  2x32 each  branch PC and sign-extended byte offset per requester.
REQ-009 res_valid  out  1  result valid.
REQ-010 res_ready  in  1  consumer accepts result.
REQ-011 res_id  out  1  index of requester that owns the result.
REQ-012 res_taken  out  1  comparison outcome.
REQ-013 res_target  out  32  branch target if taken, else req_pc+4.
REQ-014 res_err  out  1  func3 was 010 or 011.

Function
REQ-015 States: IDLE, EVAL, RESP; exactly one active.
REQ-016 IDLE: req_ready asserted only for the granted requester; grant goes to any valid requester; if both are valid, the one not granted last wins (round-robin).
REQ-017 Handshake req_valid&req_ready in IDLE latches func3/rs1/rs2/pc/off and the id, updates last-grant, and moves to EVAL next cycle.
REQ-018 req_ready = 0 in EVAL and RESP; request inputs ignored there.
REQ-019 EVAL: single shared comparator evaluates latched operands (signed for BLT/BGE, unsigned for BLTU/BGEU); taken/target/err registered; go to RESP. Lasts one cycle.
REQ-020 res_target = (pc + off) mod 2^32 when taken, (pc + 4) mod 2^32 when not taken; no alignment adjustment; carry out discarded.
REQ-021 Illegal func3 (010, 011): res_taken=0, res_err=1, res_target=pc+4.
REQ-022 RESP: res_valid=1; outputs stable until res_valid&res_ready; on that handshake go to IDLE next cycle.
REQ-023 Latency: request accept at cycle N, res_valid at cycle N+2; minimum issue interval 3 cycles.
REQ-024 res_valid=0 outside RESP; res_taken/res_target/res_err/res_id hold last values.
REQ-025 Requester that drops req_valid before grant is not served; no request queued internally.

Reset
REQ-026 rst asserted at any clock edge, including mid-EVAL or mid-RESP, forces IDLE and discards any in-flight result.
REQ-027 Reset values: res_valid=0, res_taken=0, res_err=0, res_id=0, res_target=0, req_ready=0 during the reset cycle, last-grant=1 so requester 0 wins the first tie.

Configuration
REQ-028 Macro BR_SCHED_STATS_EN: when defined, adds outputs stat_taken and stat_nottaken (16 bits each), incremented on each RESP handshake by outcome, saturating at 16'hFFFF, illegal-func3 results counted in neither, cleared by rst.
REQ-029 Without BR_SCHED_STATS_EN the stat ports and counters do not exist; all other behaviour identical.

Verification
REQ-030 Req0 BEQ rs1=rs2=0x5, pc=0x100, off=0x20, res_ready=1 -> res_valid 2 cycles after accept, taken=1, target=0x120, id=0.
REQ-031 Both valid every cycle, BNE rs1=1 rs2=2 -> grants alternate 0,1,0,1 starting with 0; each result taken=1.
REQ-032 Req1 BLT rs1=0xFFFFFFFF rs2=0x1 -> taken=1; same operands BLTU -> taken=0, target=pc+4.
REQ-033 pc=0xFFFFFFF0, off=0x20, BGE equal operands -> taken=1, target=0x00000010.
REQ-034 func3=010 -> res_err=1, taken=0; res_ready held low 5 cycles -> outputs stable, req_ready=0 throughout.
REQ-035 rst pulsed during RESP -> next cycle res_valid=0, state IDLE, next tie granted to requester 0; with BR_SCHED_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_cmp_sched.sv
// Round-robin scheduler for two branch requesters sharing one comparator.
// Optional macro BR_SCHED_STATS_EN adds saturating taken/not-taken counters.
module branch_cmp_sched #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][2:0]  req_func3,
    input  logic [NREQ-1:0][31:0] req_rs1,
    input  logic [NREQ-1:0][31:0] req_rs2,
    input  logic [NREQ-1:0][31:0] req_pc,
    input  logic [NREQ-1:0][31:0] req_off,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic                  res_taken,
    output logic [31:0]           res_target,
    output logic                  res_err
`ifdef BR_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_taken,
    output logic [15:0]           stat_nottaken
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [1:0]  grant_s;
    logic        accept_s;
    logic        gid_s;
    logic        last_r;
    logic        id_r;
    logic [2:0]  func3_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [31:0] pc_r;
    logic [31:0] off_r;
    logic        taken_s;
    logic        err_s;
    logic [31:0] target_s;

    function automatic logic is_illegal(input logic [2:0] f);
        return (f == 3'b010) || (f == 3'b011);
    endfunction

    function automatic logic cmp_taken(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        logic t;
        case (f)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) <  $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a <  b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Grant selection: the requester not granted last wins a tie
    always_comb begin
        grant_s = 2'b00;
        if ((state_r == IDLE) && !rst) begin
            if (req_valid[0] && req_valid[1]) begin
                grant_s = last_r ? 2'b01 : 2'b10;
            end else if (req_valid[0]) begin
                grant_s = 2'b01;
            end else if (req_valid[1]) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    assign req_ready = grant_s;
    assign accept_s  = |grant_s;
    assign gid_s     = grant_s[1];

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_s = EVAL;
                end else begin
                    next_s = IDLE;
                end
            end
            EVAL: next_s = RESP;
            RESP: begin
                if (res_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = RESP;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Shared comparator and single target adder over the latched operands
    always_comb begin
        err_s    = is_illegal(func3_r);
        taken_s  = err_s ? 1'b0 : cmp_taken(func3_r, rs1_r, rs2_r);
        target_s = pc_r + (taken_s ? off_r : 32'd4);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Operand capture and round-robin history on request handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            func3_r <= 3'd0;
            rs1_r   <= 32'd0;
            rs2_r   <= 32'd0;
            pc_r    <= 32'd0;
            off_r   <= 32'd0;
            id_r    <= 1'b0;
            last_r  <= 1'b1;
        end else if (accept_s) begin
            func3_r <= req_func3[gid_s];
            rs1_r   <= req_rs1[gid_s];
            rs2_r   <= req_rs2[gid_s];
            pc_r    <= req_pc[gid_s];
            off_r   <= req_off[gid_s];
            id_r    <= gid_s;
            last_r  <= gid_s;
        end
    end

    // Result registers: loaded in EVAL, held until the next evaluation
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= 32'd0;
            res_err    <= 1'b0;
        end else if (state_r == EVAL) begin
            res_valid  <= 1'b1;
            res_id     <= id_r;
            res_taken  <= taken_s;
            res_target <= target_s;
            res_err    <= err_s;
        end else if ((state_r == RESP) && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef BR_SCHED_STATS_EN
    // Saturating outcome counters, illegal results excluded
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_taken    <= 16'd0;
            stat_nottaken <= 16'd0;
        end else if ((state_r == RESP) && res_ready && !res_err) begin
            if (res_taken) begin
                if (stat_taken != 16'hFFFF) begin
                    stat_taken <= stat_taken + 16'd1;
                end
            end else begin
                if (stat_nottaken != 16'hFFFF) begin
                    stat_nottaken <= stat_nottaken + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_cmp_sched.sv
// Directed self-checking bench for branch_cmp_sched (honours BR_SCHED_STATS_EN).
module tb_branch_cmp_sched;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_func3;
    logic [1:0][31:0] req_rs1;
    logic [1:0][31:0] req_rs2;
    logic [1:0][31:0] req_pc;
    logic [1:0][31:0] req_off;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             res_err;
`ifdef BR_SCHED_STATS_EN
    logic [15:0]      stat_taken;
    logic [15:0]      stat_nottaken;
`endif

    int total = 0;
    int bad   = 0;

    branch_cmp_sched #(.NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func3  (req_func3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_pc     (req_pc),
        .req_off    (req_off),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_taken  (res_taken),
        .res_target (res_target),
        .res_err    (res_err)
`ifdef BR_SCHED_STATS_EN
        ,
        .stat_taken    (stat_taken),
        .stat_nottaken (stat_nottaken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [31:0] off);
        req_func3[id] = f;
        req_rs1[id]   = a;
        req_rs2[id]   = b;
        req_pc[id]    = pc;
        req_off[id]   = off;
    endtask

    // One full transaction on requester id; called at the start of an IDLE cycle
    task automatic run_one(input string tag, input int id, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off,
                           input logic exp_taken, input logic [31:0] exp_target,
                           input logic exp_err);
        logic [1:0] onehot;
        onehot = (id == 1) ? 2'b10 : 2'b01;
        set_req(id, f, a, b, pc, off);
        req_valid = onehot;
        res_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, {30'd0, req_ready}, {30'd0, onehot});
        cyc();
        req_valid = 2'b11;
        #1;
        chk({tag, "_eval_ready"}, {30'd0, req_ready}, 32'd0);
        chk({tag, "_eval_valid"}, {31'd0, res_valid}, 32'd0);
        cyc();
        req_valid = 2'b00;
        #1;
        chk({tag, "_valid"},  {31'd0, res_valid}, 32'd1);
        chk({tag, "_id"},     {31'd0, res_id}, id);
        chk({tag, "_taken"},  {31'd0, res_taken}, {31'd0, exp_taken});
        chk({tag, "_target"}, res_target, exp_target);
        chk({tag, "_err"},    {31'd0, res_err}, {31'd0, exp_err});
        cyc();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
        end

        // reset state
        cyc();
        chk("rst_ready",  {30'd0, req_ready}, 32'd0);
        chk("rst_valid",  {31'd0, res_valid}, 32'd0);
        chk("rst_taken",  {31'd0, res_taken}, 32'd0);
        chk("rst_err",    {31'd0, res_err}, 32'd0);
        chk("rst_id",     {31'd0, res_id}, 32'd0);
        chk("rst_target", res_target, 32'd0);
        cyc();
        rst       = 1'b0;
        req_valid = 2'b00;

        // both requesters valid every cycle: grants alternate 0,1,0,1
        set_req(0, 3'b001, 32'd1, 32'd2, 32'h200, 32'h40);
        set_req(1, 3'b001, 32'd1, 32'd2, 32'h300, 32'h10);
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {30'd0, req_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
            cyc();
            chk("rr_eval_ready", {30'd0, req_ready}, 32'd0);
            cyc();
            chk("rr_valid",  {31'd0, res_valid}, 32'd1);
            chk("rr_id",     {31'd0, res_id}, i % 2);
            chk("rr_taken",  {31'd0, res_taken}, 32'd1);
            chk("rr_target", res_target, (i % 2 == 1) ? 32'h310 : 32'h240);
            cyc();
        end
        req_valid = 2'b00;
        #1;
        cyc();

        run_one("beq",  0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0);
        run_one("blt",  1, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h400, 32'h80, 1'b1, 32'h480, 1'b0);
        run_one("bltu", 1, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h400, 32'h80, 1'b0, 32'h404, 1'b0);
        run_one("bge_wrap", 0, 3'b101, 32'h7, 32'h7, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10, 1'b0);
        run_one("ill011", 1, 3'b011, 32'h9, 32'h9, 32'h600, 32'h40, 1'b0, 32'h604, 1'b1);

        // illegal func3 with consumer stalling five cycles
        set_req(0, 3'b010, 32'h3, 32'h3, 32'h500, 32'h8);
        req_valid = 2'b01;
        res_ready = 1'b0;
        #1;
        chk("stall_accept", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b11;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",  {31'd0, res_valid}, 32'd1);
            chk("stall_ready",  {30'd0, req_ready}, 32'd0);
            chk("stall_err",    {31'd0, res_err}, 32'd1);
            chk("stall_taken",  {31'd0, res_taken}, 32'd0);
            chk("stall_target", res_target, 32'h504);
            cyc();
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        cyc();
        chk("hold_valid",  {31'd0, res_valid}, 32'd0);
        chk("hold_err",    {31'd0, res_err}, 32'd1);
        chk("hold_target", res_target, 32'h504);

`ifdef BR_SCHED_STATS_EN
        chk("stat_taken",    {16'd0, stat_taken}, 32'd7);
        chk("stat_nottaken", {16'd0, stat_nottaken}, 32'd1);
`endif

        // reset during RESP; requester 0 granted last so only reset restores its priority
        set_req(0, 3'b000, 32'h1, 32'h1, 32'h700, 32'h4);
        req_valid = 2'b01;
        res_ready = 1'b0;
        cyc();
        req_valid = 2'b00;
        cyc();
        chk("mid_valid", {31'd0, res_valid}, 32'd1);
        rst       = 1'b1;
        req_valid = 2'b11;
        cyc();
        chk("rstr_valid",  {31'd0, res_valid}, 32'd0);
        chk("rstr_taken",  {31'd0, res_taken}, 32'd0);
        chk("rstr_target", res_target, 32'd0);
`ifdef BR_SCHED_STATS_EN
        chk("rstr_stat_taken",    {16'd0, stat_taken}, 32'd0);
        chk("rstr_stat_nottaken", {16'd0, stat_nottaken}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rstr_tie", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
